// File: rtl/dma_c2h_desc_sched.sv
// Round-robin scheduler sharing the XDMA C2H descriptor-bypass channel among NUM_REQ requesters.
// Requests are split into MAX_CHUNK descriptors; at most MAX_OUT descriptors are in flight.
module dma_c2h_desc_sched #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_CHUNK = 4096,
    parameter int MAX_OUT   = 8
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_len,
    input  logic                  c2h_dsc_byp_ready,
    output logic                  c2h_dsc_byp_load,
    output logic [63:0]           c2h_dsc_byp_addr,
    output logic [31:0]           c2h_dsc_byp_len,
    output logic [2:0]            dsc_req_id,
    output logic                  dsc_last,
    input  logic                  cpl_pulse,
    output logic [7:0]            outstanding,
    output logic                  cpl_err
);
    localparam logic [31:0] CHUNK_MAX = 32'(MAX_CHUNK);
    localparam logic [7:0]  OUT_MAX   = 8'(MAX_OUT);
    localparam logic [3:0]  NREQ      = 4'(NUM_REQ);

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic logic [31:0] clamp_chunk(input logic [31:0] len);
        return (len > CHUNK_MAX) ? CHUNK_MAX : len;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] addr_d;
    logic [31:0] len_d;
    logic [2:0]  id_d;
    logic        last_d, load_d;
    logic [7:0]  out_d;
    logic        err_d;

    logic [7:0]  valid_pad;
    logic [63:0] addr_arr [8];
    logic [31:0] len_arr  [8];
    logic        grant_vld, grant_fire, accept;
    logic [2:0]  grant_id;
    logic [31:0] grant_len, rem_next;

    // Widen the per-requester buses to 8 entries so a 3-bit id indexes them directly.
    for (genvar i = 0; i < 8; i++) begin : g_pad
        if (i < NUM_REQ) begin : g_used
            assign valid_pad[i] = req_valid[i];
            assign addr_arr[i]  = req_addr[64*i +: 64];
            assign len_arr[i]   = req_len[32*i +: 32];
        end else begin : g_unused
            assign valid_pad[i] = 1'b0;
            assign addr_arr[i]  = '0;
            assign len_arr[i]   = '0;
        end
    end

    always_comb begin
        logic [3:0] scan;
        grant_vld = 1'b0;
        grant_id  = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + 4'(k);
            if (scan >= NREQ) scan = scan - NREQ;
            if (!grant_vld && valid_pad[scan[2:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan[2:0];
            end
        end
    end

    // Acknowledge is suppressed during reset so no request is consumed without being latched.
    assign grant_fire = (state_q == IDLE) && grant_vld && !pcie_rst;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = grant_fire && (grant_id == 3'(i));
    end

    assign grant_len = len_arr[grant_id];
    assign accept    = c2h_dsc_byp_load && c2h_dsc_byp_ready;
    assign rem_next  = rem_q - c2h_dsc_byp_len;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rem_d    = rem_q;
        addr_d   = c2h_dsc_byp_addr;
        len_d    = c2h_dsc_byp_len;
        id_d     = dsc_req_id;
        last_d   = dsc_last;
        out_d    = outstanding;
        err_d    = cpl_err;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    rr_ptr_d = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                    id_d     = grant_id;
                    addr_d   = addr_arr[grant_id];
                    rem_d    = grant_len;
                    len_d    = clamp_chunk(grant_len);
                    last_d   = (grant_len <= CHUNK_MAX);
                    if (grant_len != 32'd0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (dsc_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = c2h_dsc_byp_addr + {32'd0, c2h_dsc_byp_len};
                        rem_d  = rem_next;
                        len_d  = clamp_chunk(rem_next);
                        last_d = (rem_next <= CHUNK_MAX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept && !cpl_pulse) begin
            out_d = outstanding + 8'd1;
        end else if (cpl_pulse && !accept) begin
            if (outstanding == 8'd0) err_d = 1'b1;
            else                     out_d = outstanding - 8'd1;
        end

        // Load can only fall by acceptance: an unaccepted load never raises the count.
        load_d = (state_d == ISSUE) && (out_d < OUT_MAX);
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            rem_q            <= '0;
            c2h_dsc_byp_load <= 1'b0;
            c2h_dsc_byp_addr <= '0;
            c2h_dsc_byp_len  <= '0;
            dsc_req_id       <= '0;
            dsc_last         <= 1'b0;
            outstanding      <= '0;
            cpl_err          <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            rem_q            <= rem_d;
            c2h_dsc_byp_load <= load_d;
            c2h_dsc_byp_addr <= addr_d;
            c2h_dsc_byp_len  <= len_d;
            dsc_req_id       <= id_d;
            dsc_last         <= last_d;
            outstanding      <= out_d;
            cpl_err          <= err_d;
        end
    end
endmodule

// File: tb/tb_dma_c2h_desc_sched.sv
// Bench for dma_c2h_desc_sched: directed scenarios followed by random traffic, each cycle
// compared with a reference model holding the expected descriptor list of the active request.
module tb_dma_c2h_desc_sched;
    localparam int NUM_REQ   = 4;
    localparam int MAX_CHUNK = 4096;
    localparam int MAX_OUT   = 8;

    logic                  pcie_clk = 1'b0;
    logic                  pcie_rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_addr = '0;
    logic [NUM_REQ*32-1:0] req_len = '0;
    logic                  c2h_dsc_byp_ready = 1'b0;
    logic                  c2h_dsc_byp_load;
    logic [63:0]           c2h_dsc_byp_addr;
    logic [31:0]           c2h_dsc_byp_len;
    logic [2:0]            dsc_req_id;
    logic                  dsc_last;
    logic                  cpl_pulse = 1'b0;
    logic [7:0]            outstanding;
    logic                  cpl_err;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic [2:0]  id;
        logic        last;
    } desc_t;

    desc_t exp_q[$];
    int    dut_grants[$];
    int    m_rr, m_out;
    bit    m_err;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 pcie_clk = ~pcie_clk;

    dma_c2h_desc_sched #(.NUM_REQ(NUM_REQ), .MAX_CHUNK(MAX_CHUNK), .MAX_OUT(MAX_OUT)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .c2h_dsc_byp_ready(c2h_dsc_byp_ready), .c2h_dsc_byp_load(c2h_dsc_byp_load),
        .c2h_dsc_byp_addr(c2h_dsc_byp_addr), .c2h_dsc_byp_len(c2h_dsc_byp_len),
        .dsc_req_id(dsc_req_id), .dsc_last(dsc_last), .cpl_pulse(cpl_pulse),
        .outstanding(outstanding), .cpl_err(cpl_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [31:0] l);
        req_addr[64*i +: 64] = a;
        req_len[32*i +: 32]  = l;
        req_valid = req_valid | (NUM_REQ'(1) << i);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr  = 0;
        m_out = 0;
        m_err = 1'b0;
    endtask

    // One cycle of the reference model: arbitration while no request is active, otherwise the
    // head of the expected descriptor list must be on the bus whenever the in-flight cap allows.
    task automatic check_cycle();
        int                 g;
        bit                 exp_load, acc;
        logic [NUM_REQ-1:0] exp_rdy;
        desc_t              d;
        logic [63:0]        base;
        longint             total, left;
        g       = -1;
        exp_rdy = '0;
        exp_load = (exp_q.size() > 0) && (m_out < MAX_OUT);
        if (exp_q.size() == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_rr + k) % NUM_REQ;
                if (g < 0 && 1'(req_valid >> i)) g = i;
            end
        end
        if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
        for (int i = 0; i < NUM_REQ; i++) if (1'(req_ready >> i)) dut_grants.push_back(i);

        chk("req_ready", req_ready, exp_rdy);
        chk("load", c2h_dsc_byp_load, exp_load);
        if (exp_load) begin
            chk("addr", c2h_dsc_byp_addr, exp_q[0].addr);
            chk("len", c2h_dsc_byp_len, exp_q[0].len);
            chk("req_id", dsc_req_id, exp_q[0].id);
            chk("last", dsc_last, exp_q[0].last);
        end
        chk("outstanding", outstanding, m_out);
        chk("cpl_err", cpl_err, m_err);

        acc = exp_load && c2h_dsc_byp_ready;
        if (acc) void'(exp_q.pop_front());
        if (acc && !cpl_pulse) m_out++;
        else if (cpl_pulse && !acc) begin
            if (m_out == 0) m_err = 1'b1;
            else            m_out--;
        end

        if (g >= 0) begin
            m_rr  = (g + 1) % NUM_REQ;
            base  = 64'(req_addr >> (64 * g));
            total = longint'(32'(req_len >> (32 * g)));
            for (longint off = 0; off < total; off += MAX_CHUNK) begin
                left   = total - off;
                d.addr = base + 64'(off);
                d.len  = (left > MAX_CHUNK) ? 32'(MAX_CHUNK) : 32'(left);
                d.id   = 3'(g);
                d.last = (left <= MAX_CHUNK);
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic cycle();
        #3;
        check_cycle();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic drain(input int budget);
        req_valid = '0;
        for (int n = 0; n < budget && (exp_q.size() > 0 || m_out > 0); n++) begin
            c2h_dsc_byp_ready = 1'b1;
            cpl_pulse = (m_out > 0);
            cycle();
        end
        cpl_pulse = 1'b0;
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        #1ms;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    initial begin
        logic [63:0] s_addr [3];
        logic [31:0] s_len  [3];
        s_addr = '{64'h1000_0000, 64'h1000_1000, 64'h1000_2000};
        s_len  = '{32'd4096, 32'd4096, 32'd1808};
        model_reset();

        @(posedge pcie_clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_load", c2h_dsc_byp_load, 0);
        chk("rst_addr", c2h_dsc_byp_addr, 0);
        chk("rst_len", c2h_dsc_byp_len, 0);
        chk("rst_id", dsc_req_id, 0);
        chk("rst_last", dsc_last, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_err", cpl_err, 0);
        @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b0;

        // Single 3-chunk request
        c2h_dsc_byp_ready = 1'b1;
        set_req(0, 64'h1000_0000, 32'd10000);
        cycle();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            chk("single_addr", c2h_dsc_byp_addr, s_addr[k]);
            chk("single_len", c2h_dsc_byp_len, s_len[k]);
            chk("single_last", dsc_last, (k == 2) ? 1 : 0);
            cycle();
        end
        chk("single_out", outstanding, 3);
        cycle();
        drain(50);

        // Round-robin with every requester continuously asking
        dut_grants.delete();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'h8000_0000 + 64'(i * 'h100), 32'd64);
        repeat (16) cycle();
        chk("rr_grants", dut_grants.size(), 8);
        for (int k = 0; k < 8 && k < dut_grants.size(); k++) chk("rr_order", dut_grants[k], (1 + k) % 4);
        drain(50);

        // In-flight cap and release by one completion
        set_req(1, 64'h2000_0000, 32'd49152);
        cycle();
        req_valid = '0;
        repeat (11) cycle();
        chk("limit_load", c2h_dsc_byp_load, 0);
        chk("limit_out", outstanding, MAX_OUT);
        cpl_pulse = 1'b1;
        cycle();
        cpl_pulse = 1'b0;
        chk("release_load", c2h_dsc_byp_load, 1);
        chk("release_addr", c2h_dsc_byp_addr, 64'h2000_8000);
        cycle();
        cycle();
        chk("release_once", c2h_dsc_byp_load, 0);
        drain(200);

        // Random ready stalls
        set_req(3, 64'h3000_0040, 32'd20000);
        c2h_dsc_byp_ready = 1'($urandom_range(0, 1));
        cycle();
        req_valid = '0;
        for (int n = 0; n < 300 && exp_q.size() > 0; n++) begin
            c2h_dsc_byp_ready = 1'($urandom_range(0, 1));
            cpl_pulse = (m_out > 0) && 1'($urandom_range(0, 1));
            cycle();
        end
        drain(100);

        // Zero-length request
        dut_grants.delete();
        set_req(2, 64'hdead_0000, 32'd0);
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        chk("zero_load", c2h_dsc_byp_load, 0);
        chk("zero_grants", dut_grants.size(), 1);
        if (dut_grants.size() > 0) chk("zero_grant_id", dut_grants[0], 2);

        // Completion with nothing outstanding, then completion coinciding with acceptance
        cpl_pulse = 1'b1;
        cycle();
        cpl_pulse = 1'b0;
        chk("err_set", cpl_err, 1);
        chk("err_out", outstanding, 0);
        set_req(0, 64'h4000_0000, 32'd64);
        cycle();
        req_valid = '0;
        cpl_pulse = 1'b1;
        cycle();
        cpl_pulse = 1'b0;
        chk("simul_out", outstanding, 0);
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_addr[64*i +: 64] = {$urandom, $urandom};
                req_len[32*i +: 32]  = 32'($urandom_range(0, 12000));
            end
            c2h_dsc_byp_ready = ($urandom_range(0, 3) != 0);
            cpl_pulse = ($urandom_range(0, 2) == 0);
            cycle();
        end
        drain(400);

        // Reset during the second chunk of a 3-chunk request
        set_req(0, 64'h5000_0000, 32'd12000);
        c2h_dsc_byp_ready = 1'b1;
        cycle();
        cycle();
        pcie_rst = 1'b1;
        #1;
        chk("mid_rst_load", c2h_dsc_byp_load, 0);
        chk("mid_rst_addr", c2h_dsc_byp_addr, 0);
        chk("mid_rst_len", c2h_dsc_byp_len, 0);
        chk("mid_rst_id", dsc_req_id, 0);
        chk("mid_rst_last", dsc_last, 0);
        chk("mid_rst_out", outstanding, 0);
        chk("mid_rst_err", cpl_err, 0);
        chk("mid_rst_ready", req_ready, 0);
        model_reset();
        @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'h6000_0000 + 64'(i * 'h1000), 32'd128);
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        cycle();
        req_valid = '0;
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
